// File: rtl/imem_fetch.sv
// Instruction memory fetch unit.
// A DEPTH x WIDTH program store is written through a load port and read through
// a one-entry registered response stage. Fetches to PCs beyond the store return
// a fault with a zero instruction word. A saturating counter tracks accepted fetches.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The ready signal never depends on valid. A valid response holds its
// payload stable until it is taken.
module imem_fetch #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_pc,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_inst,
  output logic             rsp_fault,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic [15:0]      fetch_cnt
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic             accept;
  logic             in_range;

  // A load cycle blocks fetches, so the store never sees a read and a write
  // in the same cycle. Reset also holds the request side closed.
  assign req_ready = rst_n && !ld_en && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

  // Any set bit above the index field means the PC lies outside the store.
  // Those PCs are reported as faults rather than aliased onto a lower word.
  assign in_range  = (req_pc[31:AW] == '0);

  // Program store write port. It has no reset, so contents survive a reset.
  // Loads are ignored while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && ld_en) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // One-entry response register. It loads on accept, holds while stalled,
  // and empties when the response is taken and no new fetch replaces it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_fault <= 1'b0;
      rsp_inst  <= '0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_fault <= !in_range;
      rsp_inst  <= in_range ? mem[req_pc[AW-1:0]] : '0;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Accepted-fetch counter. It counts faulting fetches too and stops at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt <= '0;
    end else if (accept && (fetch_cnt != 16'hFFFF)) begin
      fetch_cnt <= fetch_cnt + 16'd1;
    end
  end

endmodule
